// File: rtl/lsu_mem_arbiter.sv
// Two-requester LSU/loader arbiter in front of a single-port word memory.
// Optional round-robin arbitration: define LSU_ARB_ROUND_ROBIN_EN.
module lsu_mem_arbiter #(
    parameter int ADDRBIT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,

    input  logic               i_r0_req,
    input  logic               i_r0_we,
    input  logic [31:0]        i_r0_addr,
    input  logic [31:0]        i_r0_wdata,
    input  logic [1:0]         i_r0_op,
    input  logic               i_r0_un,
    output logic               o_r0_gnt,
    output logic               o_r0_done,
    output logic               o_r0_err,
    output logic [31:0]        o_r0_rdata,

    input  logic               i_r1_req,
    input  logic               i_r1_we,
    input  logic [31:0]        i_r1_addr,
    input  logic [31:0]        i_r1_wdata,
    input  logic [1:0]         i_r1_op,
    input  logic               i_r1_un,
    output logic               o_r1_gnt,
    output logic               o_r1_done,
    output logic               o_r1_err,
    output logic [31:0]        o_r1_rdata,

    output logic [ADDRBIT-3:0] o_mem_addr,
    output logic [31:0]        o_mem_wdata,
    output logic               o_mem_wren,
    input  logic [31:0]        i_mem_rdata,

    output logic               o_busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic               own;
    logic               we_q;
    logic               un_q;
    logic               err_q;
    logic [1:0]         op_q;
    logic [ADDRBIT-1:0] addr_q;
    logic [31:0]        data_q;

    logic               any_req;
    logic               sel;
    logic               grant;
    logic               fault;
    logic               sel_we;
    logic               sel_un;
    logic [1:0]         sel_op;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [31:0]        rd;

    // Load formatting: pick the addressed half/byte and extend it.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  op,
        input logic        un,
        input logic [1:0]  a
    );
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = a[0] ? h[15:8] : h[7:0];
        if (!op[1])
            fmt_load = w;
        else if (!op[0])
            fmt_load = {{16{h[15] & ~un}}, h};
        else
            fmt_load = {{24{b[7] & ~un}}, b};
    endfunction

    // Store merge: replace only the addressed half/byte of the read word.
    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [15:0] d,
        input logic [1:0]  op,
        input logic [1:0]  a
    );
        if (!op[0]) begin
            merge = a[1] ? {d, w[15:0]} : {w[31:16], d};
        end else begin
            case (a)
                2'd0:    merge = {w[31:8], d[7:0]};
                2'd1:    merge = {w[31:16], d[7:0], w[7:0]};
                2'd2:    merge = {w[31:24], d[7:0], w[15:0]};
                default: merge = {d[7:0], w[23:0]};
            endcase
        end
    endfunction

    assign any_req = i_r0_req | i_r1_req;

`ifdef LSU_ARB_ROUND_ROBIN_EN
    logic last_q;

    assign sel = (i_r0_req & i_r1_req) ? ~last_q : i_r1_req;

    // Remember which requester was granted last; starts as "1".
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            last_q <= 1'b1;
        else if (grant)
            last_q <= sel;
    end
`else
    assign sel = ~i_r0_req;
`endif

    assign grant     = i_reset_n & (state == IDLE) & any_req;
    assign sel_we    = sel ? i_r1_we    : i_r0_we;
    assign sel_un    = sel ? i_r1_un    : i_r0_un;
    assign sel_op    = sel ? i_r1_op    : i_r0_op;
    assign sel_addr  = sel ? i_r1_addr  : i_r0_addr;
    assign sel_wdata = sel ? i_r1_wdata : i_r0_wdata;
    assign fault     = (sel_addr >> ADDRBIT) != 32'd0;

    // Next-state selection for the transaction sequencer.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (fault)
                        state_nx = DONE;
                    else if (sel_we && !sel_op[1])
                        state_nx = WRITE;
                    else
                        state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus the latched transaction and its data word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            own    <= 1'b0;
            we_q   <= 1'b0;
            un_q   <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= 2'b00;
            addr_q <= '0;
            data_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (grant) begin
                own    <= sel;
                we_q   <= sel_we;
                un_q   <= sel_un;
                err_q  <= fault;
                op_q   <= sel_op;
                addr_q <= sel_addr[ADDRBIT-1:0];
                data_q <= sel_wdata;
            end else if (state == CAPTURE) begin
                if (we_q)
                    data_q <= merge(i_mem_rdata, data_q[15:0],
                                    op_q, addr_q[1:0]);
                else
                    data_q <= fmt_load(i_mem_rdata, op_q, un_q,
                                       addr_q[1:0]);
            end
        end
    end

    assign rd = (we_q | err_q) ? 32'd0 : data_q;

    assign o_r0_gnt   = grant & ~sel;
    assign o_r1_gnt   = grant & sel;
    assign o_r0_done  = (state == DONE) & ~own;
    assign o_r1_done  = (state == DONE) & own;
    assign o_r0_err   = o_r0_done & err_q;
    assign o_r1_err   = o_r1_done & err_q;
    assign o_r0_rdata = o_r0_done ? rd : 32'd0;
    assign o_r1_rdata = o_r1_done ? rd : 32'd0;

    assign o_mem_addr  = addr_q[ADDRBIT-1:2];
    assign o_mem_wdata = data_q;
    assign o_mem_wren  = (state == WRITE);
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Randomized self-checking bench for lsu_mem_arbiter.
// Reference model: word-array memory plus arithmetic load/merge rules.
module tb_lsu_mem_arbiter;

`ifdef LSU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int AB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       rq, we, un, gnt, done, err;
    logic [1:0][1:0]  op;
    logic [1:0][31:0] addr, wdata, rdata;

    logic [AB-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_wren;
    logic [31:0]   mem_rdata;
    logic          busy;

    logic [31:0] mem  [0:16383];
    logic [31:0] refm [0:16383];

    int n_checks = 0;
    int n_fail   = 0;
    int last     = 1;
    int g_act;
    int wr_cyc;
    logic [31:0] wr_data;
    logic [31:0] last_rd;
    logic        last_err;

    always #5 clk = ~clk;

    lsu_mem_arbiter dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_r0_req(rq[0]), .i_r0_we(we[0]), .i_r0_addr(addr[0]),
        .i_r0_wdata(wdata[0]), .i_r0_op(op[0]), .i_r0_un(un[0]),
        .o_r0_gnt(gnt[0]), .o_r0_done(done[0]), .o_r0_err(err[0]),
        .o_r0_rdata(rdata[0]),
        .i_r1_req(rq[1]), .i_r1_we(we[1]), .i_r1_addr(addr[1]),
        .i_r1_wdata(wdata[1]), .i_r1_op(op[1]), .i_r1_un(un[1]),
        .o_r1_gnt(gnt[1]), .o_r1_done(done[1]), .o_r1_err(err[1]),
        .o_r1_rdata(rdata[1]),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata),
        .o_busy(busy)
    );

    // Synchronous-read word memory seen by the arbiter.
    always @(posedge clk) begin
        if (mem_wren)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w,
                                           input logic [1:0] o,
                                           input logic u,
                                           input logic [1:0] a);
        logic [31:0] v;
        if (o[1] == 1'b0) return w;
        if (o == 2'b10) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w,
                                            input logic [31:0] d,
                                            input logic [1:0] o,
                                            input logic [1:0] a);
        logic [31:0] mask;
        int sh;
        if (o[1] == 1'b0) return d;
        sh   = (o == 2'b10) ? 16 * a[1] : 8 * a;
        mask = ((o == 2'b10) ? 32'hFFFF : 32'hFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic set_req(input int n, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] o,
                           input logic u);
        rq[n] = 1'b1; we[n] = w; addr[n] = a;
        wdata[n] = d; op[n] = o; un[n] = u;
    endtask

    task automatic rand_req(input int n);
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(1, 65535) << 16) | $urandom_range(0, 63);
        else
            a = 32'h400 + $urandom_range(0, 63);
        set_req(n, 1'(($urandom)), a, $urandom, 2'($urandom), 1'($urandom));
    endtask

    // One transaction; entered at a negedge in IDLE with a request pending.
    task automatic serve_one();
        int w, c, nwr, lat, idx;
        bit got, stray, leak, other, flt;
        logic        s_we, s_un;
        logic [1:0]  s_op;
        logic [31:0] s_addr, s_wd, e_rd;
        #1;
        if (rq == 2'b11) w = (RR && last == 0) ? 1 : 0;
        else w = rq[1] ? 1 : 0;
        g_act = gnt[1] ? 1 : 0;
        check("gnt0", {31'd0, gnt[0]}, {31'd0, w == 0});
        check("gnt1", {31'd0, gnt[1]}, {31'd0, w == 1});
        check("busy_idle", {31'd0, busy}, 32'd0);
        s_we = we[w]; s_un = un[w]; s_op = op[w];
        s_addr = addr[w]; s_wd = wdata[w];
        @(posedge clk);
        #1;
        rq[w] = 1'b0;
        addr[w] = $urandom; wdata[w] = $urandom;
        we[w] = 1'($urandom); op[w] = 2'($urandom);
        c = 0; nwr = 0; got = 0; stray = 0; leak = 0; other = 0;
        wr_cyc = -1; wr_data = 32'd0;
        while (!got && c < 12) begin
            @(negedge clk);
            c++;
            if (gnt != 2'b00) stray = 1;
            if (done[w]) begin
                got = 1;
                last_rd = rdata[w];
                last_err = err[w];
                if (done[1-w] || err[1-w] || rdata[1-w] != 0) other = 1;
            end else begin
                if (rdata != '0 || err != 2'b00) leak = 1;
                if (mem_wren) begin
                    nwr++; wr_cyc = c; wr_data = mem_wdata;
                end
            end
        end
        flt = (s_addr >> AB) != 0;
        idx = int'(s_addr[AB-1:2]);
        if (flt) lat = 1;
        else if (!s_we) lat = 3;
        else if (s_op[1] == 1'b0) lat = 2;
        else lat = 4;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", c, lat);
        check("err", {31'd0, last_err}, {31'd0, flt});
        check("wren_count", nwr, (s_we && !flt) ? 1 : 0);
        check("stray_gnt", {31'd0, stray}, 32'd0);
        check("leak", {31'd0, leak}, 32'd0);
        check("other_side", {31'd0, other}, 32'd0);
        if (flt) begin
            check("rdata_fault", last_rd, 32'd0);
        end else if (!s_we) begin
            e_rd = m_load(refm[idx], s_op, s_un, s_addr[1:0]);
            check("rdata", last_rd, e_rd);
        end else begin
            refm[idx] = m_store(refm[idx], s_wd, s_op, s_addr[1:0]);
            check("memword", mem[idx], refm[idx]);
        end
        last = w;
        @(negedge clk);
    endtask

    task automatic serve();
        while (rq != 2'b00) serve_one();
    endtask

    initial begin
        int nd;
        logic [31:0] keep;
        rq = '0; we = '0; un = '0; op = '0; addr = '0; wdata = '0;
        #3;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);
        check("rst_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_maddr", {18'd0, mem_addr}, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            set_req(i % 2, 1'b1, 32'h400 + 4 * i, $urandom, 2'b00, 1'b0);
            serve();
        end

        set_req(0, 1'b1, 32'h400, 32'h1122_3344, 2'b00, 1'b0);
        serve();
        set_req(0, 1'b1, 32'h402, 32'h0000_00AA, 2'b11, 1'b0);
        serve();
        check("sb_wr_cycle", wr_cyc, 3);
        check("sb_wdata", wr_data, 32'h11AA_3344);

        set_req(0, 1'b1, 32'h400, 32'h8081_7F80, 2'b00, 1'b0);
        serve();
        set_req(0, 1'b0, 32'h400, 32'd0, 2'b11, 1'b0);
        serve();
        check("lb_400", last_rd, 32'hFFFF_FF80);
        set_req(0, 1'b0, 32'h401, 32'd0, 2'b11, 1'b0);
        serve();
        check("lb_401", last_rd, 32'h0000_007F);
        set_req(0, 1'b0, 32'h402, 32'd0, 2'b10, 1'b1);
        serve();
        check("lhu_402", last_rd, 32'h0000_8081);

        set_req(1, 1'b0, 32'h1000_0000, 32'd0, 2'b00, 1'b0);
        serve();
        check("fault_err", {31'd0, last_err}, 32'd1);
        check("fault_rdata", last_rd, 32'd0);

        set_req(0, 1'b0, 32'h404, 32'd0, 2'b00, 1'b0);
        set_req(1, 1'b0, 32'h408, 32'd0, 2'b00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            serve_one();
            check("alternate", g_act, RR ? (k % 2) : 0);
            set_req(g_act, 1'b0, 32'h404 + 4 * g_act, 32'd0, 2'b00, 1'b0);
        end
        serve();

        keep = refm[32'h101];
        set_req(0, 1'b1, 32'h404, 32'hDEAD_BEEF, 2'b00, 1'b0);
        #1;
        check("rst_t_gnt", {31'd0, gnt[0]}, 32'd1);
        @(posedge clk);
        #1;
        rq[0] = 1'b0;
        @(negedge clk);
        check("rst_t_wren_pre", {31'd0, mem_wren}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_t_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_t_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last = 1;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done != 2'b00) nd++;
        end
        check("rst_t_nodone", nd, 0);
        check("rst_t_mem", mem[32'h101], keep);

        for (int t = 0; t < 200; t++) begin
            if (!rq[0] && $urandom_range(0, 1) == 1) rand_req(0);
            if (!rq[1] && $urandom_range(0, 1) == 1) rand_req(1);
            if (rq == 2'b00) rand_req($urandom_range(0, 1));
            serve_one();
        end
        serve();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
